// File: rtl/uart_rx_fifo_pkg.sv
// Shared IO-map constants and helpers for the UART receive FIFO.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
//
// IO bit indices select the UART blocks on the rcpu IO bus.
// Status-word bit positions place the UART flags in the status read.
package uart_rx_fifo_pkg;

    // IO address bits decoded by the top-level read/write mux
    localparam int IO_UART     = 12;
    localparam int IO_MISC_IN  = 13;
    localparam int IO_UART_LVL = 14;

    // Status-word bit positions
    localparam int STAT_RXVALID = 0;
    localparam int STAT_TXREADY = 1;
    localparam int STAT_RXOVF   = 2;

    // Highest fill level at which the peer is still allowed to send.
    // Above it, HEADROOM free slots remain to absorb bytes already in flight.
    function automatic int cts_threshold(input int depth, input int headroom);
        return depth - headroom - 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ram8.sv
// DEPTH x 8 storage for the UART receive FIFO: one write port, asynchronous read.
// Latency: write visible on rdata the cycle after we; read is combinational.
// Backpressure: none; the caller guarantees a write only targets a free slot.
//
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (async read port).
// Kept as plain registers so small depths map to distributed logic, not block RAM.
module uart_rx_fifo_ram8
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Contents are not reset; the FIFO masks stale data with its own count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with sticky overflow flag and registered CTS flow control.
// Latency: a pushed byte appears on rd_data/not_empty one cycle later; rd_data is show-ahead.
// Backpressure: cts drops near full; a byte arriving when full (without a pop) is dropped and sets overflow.
//
// Ports: clk, reset (sync, active-high); rx_valid/rx_data from the UART receiver;
// rd pops the head, clr_ovf clears overflow; rd_data, not_empty, full, overflow, cts.
// Optional: define UART_RX_FIFO_LEVEL_EN to add output `level` (= current fill count).
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int HEADROOM = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    rd,
    input  logic                    clr_ovf,
    output logic [7:0]              rd_data,
    output logic                    not_empty,
    output logic                    full,
    output logic                    overflow,
    output logic                    cts
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] CTS_THR = (AW+1)'(cts_threshold(DEPTH, HEADROOM));

    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two in 4..256");
    end
    if (HEADROOM < 1 || HEADROOM > DEPTH - 1) begin : g_bad_headroom
        $error("uart_rx_fifo: HEADROOM must be in 1..DEPTH-1");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow_q;
    logic          cts_q;
    logic          push;
    logic          pop;
    logic          drop;
    logic [7:0]    ram_rdata;

    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_C);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign pop  = rd & not_empty;
    assign push = rx_valid & (~full | pop);
    assign drop = rx_valid & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            cts_q      <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A fresh drop wins over a clear issued in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
            // Registered from the current count, so cts lags the fill level by one cycle.
            cts_q <= (count <= CTS_THR);
        end
    end

    uart_rx_fifo_ram8 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push & ~reset),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Memory is not cleared on reset, so mask the head when nothing is stored.
    assign rd_data  = not_empty ? ram_rdata : 8'h00;
    assign overflow = overflow_q;
    assign cts      = cts_q;

`ifdef UART_RX_FIFO_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, HEADROOM=4).
// Latency: inputs applied #1 after a posedge, outputs sampled #1 after the next posedge.
// Backpressure: exercises full, overflow, simultaneous push/pop and cts drop.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       not_empty;
    logic       full;
    logic       overflow;
    logic       cts;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH    (16),
        .HEADROOM (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rd        (rd),
        .clr_ovf   (clr_ovf),
        .rd_data   (rd_data),
        .not_empty (not_empty),
        .full      (full),
        .overflow  (overflow),
        .cts       (cts)
`ifdef UART_RX_FIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; returns #1 after the edge with strobes cleared.
    task automatic tick(input logic v, input logic [7:0] d, input logic r, input logic c);
        rx_valid = v;
        rx_data  = d;
        rd       = r;
        clr_ovf  = c;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rd       = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    logic [7:0] exp_b;

    initial begin
        #1;
        // ---- reset state
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();
        check("rst_not_empty", 32'(not_empty), 0);
        check("rst_full",      32'(full),      0);
        check("rst_rd_data",   32'(rd_data),   0);
        check("rst_cts",       32'(cts),       1);
        check("rst_overflow",  32'(overflow),  0);

        // ---- basic push of three bytes, then pop in order
        tick(1'b1, 8'h41, 1'b0, 1'b0);
        check("push1_not_empty", 32'(not_empty), 1);
        check("push1_rd_data",   32'(rd_data),   32'h41);
        tick(1'b1, 8'h42, 1'b0, 1'b0);
        tick(1'b1, 8'h43, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_b = 8'h41 + 8'(i);
            check("basic_head", 32'(rd_data), 32'(exp_b));
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("basic_drained_not_empty", 32'(not_empty), 0);
        check("basic_drained_rd_data",   32'(rd_data),   0);
        // read while empty is a no-op
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("underflow_not_empty", 32'(not_empty), 0);
        check("underflow_rd_data",   32'(rd_data),   0);
        check("underflow_full",      32'(full),      0);

        // ---- fill to 16; cts follows the count of the previous cycle
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1, 8'(k), 1'b0, 1'b0);
            check("fill_cts", 32'(cts), (k <= 12) ? 1 : 0);
            check("fill_full", 32'(full), (k == 16) ? 1 : 0);
        end
        tick(1'b1, 8'hFF, 1'b0, 1'b0);
        check("drop_overflow", 32'(overflow), 1);
        check("drop_full",     32'(full),     1);
        for (int k = 1; k <= 16; k++) begin
            check("drain_head", 32'(rd_data), k);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_not_empty", 32'(not_empty), 0);
        check("drain_overflow_sticky", 32'(overflow), 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_overflow", 32'(overflow), 0);
        check("drain_cts", 32'(cts), 1);

        // ---- full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        end
        check("sim_pre_full", 32'(full), 1);
        check("sim_pre_head", 32'(rd_data), 32'h20);
        tick(1'b1, 8'hAA, 1'b1, 1'b0);
        check("sim_full",     32'(full),     1);
        check("sim_overflow", 32'(overflow), 0);
        for (int i = 1; i < 16; i++) begin
            check("sim_head", 32'(rd_data), 32'h20 + i);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("sim_last_head", 32'(rd_data), 32'hAA);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        check("sim_empty", 32'(not_empty), 0);

        // ---- wrap: alternating push/pop across the pointer boundary
        for (int i = 0; i < 40; i++) begin
            exp_b = 8'h80 + 8'(i);
            tick(1'b1, exp_b, 1'b0, 1'b0);
            check("wrap_head", 32'(rd_data), 32'(exp_b));
            check("wrap_full", 32'(full), 0);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_empty", 32'(not_empty), 0);
        end

        // ---- overflow set beats clear in the same cycle
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        end
        tick(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 1);
        tick(1'b1, 8'hEF, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clear", 32'(overflow), 0);
        check("ovf_head_kept", 32'(rd_data), 32'h50);

        // ---- reset at count 5 discards contents; reset dominates a push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        end
        check("pre_rst_head", 32'(rd_data), 32'h60);
`ifdef UART_RX_FIFO_LEVEL_EN
        check("pre_rst_level", 32'(level), 5);
`endif
        reset = 1'b1;
        tick(1'b1, 8'h77, 1'b1, 1'b0);
        reset = 1'b0;
        check("rst5_not_empty", 32'(not_empty), 0);
        check("rst5_cts",       32'(cts),       1);
        check("rst5_full",      32'(full),      0);
        check("rst5_rd_data",   32'(rd_data),   0);
`ifdef UART_RX_FIFO_LEVEL_EN
        check("rst5_level", 32'(level), 0);
`endif
        tick(1'b1, 8'h99, 1'b0, 1'b0);
        check("post_rst_head", 32'(rd_data), 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
